rst_seq: RTL

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_pkg.sv | 20 ++
 rtl/rst_sync_chain.sv | 27 ++
 rtl/rst_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// Shared types and default constants for the reset sequencer.
package rst_pkg;

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } seq_state_t;

   localparam int DEF_STAGES   = 2;
   localparam int DEF_CHANNELS = 3;
   localparam int DEF_HOLD     = 4;
   localparam int DEF_GAP      = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchroniser: async set, shifts zeros in once rst_async drops.
module rst_sync_chain
   import rst_pkg::*;
#(
   parameter int pSTAGES = DEF_STAGES
) (
   input  logic clk,
   input  logic rst_async,
   output logic sync_arm,
   output logic sync_out
);

   logic [pSTAGES-1:0] sync_reg;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[pSTAGES-2:0], 1'b0};
      end
   end

   // sync_arm is the value sync_out takes on the next edge
   assign sync_arm = sync_reg[pSTAGES-2];
   assign sync_out = sync_reg[pSTAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Sequenced reset release: hold all channels, then drop them in ascending order.
// Define RST_SEQ_SW_REQ_EN to add the sw_rst_req software reset path.
module rst_seq
   import rst_pkg::*;
#(
   parameter int pSTAGES   = DEF_STAGES,
   parameter int pCHANNELS = DEF_CHANNELS,
   parameter int pHOLD     = DEF_HOLD,
   parameter int pGAP      = DEF_GAP
) (
   input  logic                 clk,
   input  logic                 rst_async,
`ifdef RST_SEQ_SW_REQ_EN
   input  logic                 sw_rst_req,
`endif
   output logic [pCHANNELS-1:0] rst_out,
   output logic                 seq_busy,
   output logic                 seq_done
);

   localparam int CNT_MAX = max2(pHOLD, pGAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(pHOLD - 1);
   localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(pGAP - 1);
   localparam logic [CNT_W-1:0]     CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [pCHANNELS-1:0] LAST_ONLY = pCHANNELS'(1) << (pCHANNELS - 1);

   logic sync_arm;
   logic sync_out;

   rst_sync_chain #(.pSTAGES(pSTAGES)) u_sync (
      .clk       (clk),
      .rst_async (rst_async),
      .sync_arm  (sync_arm),
      .sync_out  (sync_out)
   );

   seq_state_t           state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [pCHANNELS-1:0] rst_out_reg;
   logic                 busy_reg;
   logic                 done_reg;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_reg   <= ST_RESET;
         cnt_reg     <= '0;
         rst_out_reg <= '1;
         busy_reg    <= 1'b1;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            // Leave on the same edge the synchroniser output falls, so the
            // hold window is measured from the synchronised release itself.
            ST_RESET: begin
               if (sync_out && !sync_arm) begin
                  state_reg <= ST_HOLD;
                  cnt_reg   <= '0;
               end
            end
            ST_HOLD: begin
`ifdef RST_SEQ_SW_REQ_EN
               if (sw_rst_req) begin
                  cnt_reg <= '0;
               end else
`endif
               if (cnt_reg == HOLD_LAST) begin
                  rst_out_reg <= rst_out_reg << 1;
                  cnt_reg     <= '0;
                  if (rst_out_reg == LAST_ONLY) begin
                     state_reg <= ST_RUN;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_RELEASE;
                  end
               end else if (cnt_reg != CNT_SAT) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt_reg == GAP_LAST) begin
                  rst_out_reg <= rst_out_reg << 1;
                  cnt_reg     <= '0;
                  if (rst_out_reg == LAST_ONLY) begin
                     state_reg <= ST_RUN;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end
               end else if (cnt_reg != CNT_SAT) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_RUN: begin
`ifdef RST_SEQ_SW_REQ_EN
               if (sw_rst_req) begin
                  state_reg   <= ST_HOLD;
                  cnt_reg     <= '0;
                  rst_out_reg <= '1;
                  busy_reg    <= 1'b1;
                  done_reg    <= 1'b0;
               end
`endif
            end
         endcase
      end
   end

   assign rst_out  = rst_out_reg;
   assign seq_busy = busy_reg;
   assign seq_done = done_reg;

endmodule
